// File: rtl/control_unit_pkg.sv
// Shared encodings for the accumulator-machine control unit: opcodes,
// FSM states, bus source selects and ALU operation codes.
package control_unit_pkg;

  // Opcodes as they appear in IR[16:12]
  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_LOAD  = 5'h01;
  localparam logic [4:0] OP_STORE = 5'h02;
  localparam logic [4:0] OP_ADD   = 5'h03;
  localparam logic [4:0] OP_SUB   = 5'h04;
  localparam logic [4:0] OP_JUMP  = 5'h05;
  localparam logic [4:0] OP_JMPZ  = 5'h06;
  localparam logic [4:0] OP_INC   = 5'h07;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  // Bus source selects
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_IR   = 3'd2;
  localparam logic [2:0] BUS_AC   = 3'd3;
  localparam logic [2:0] BUS_MEM  = 3'd4;

  // ALU operations
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_INC  = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F_ADDR = 3'd1,
    ST_F_MEM  = 3'd2,
    ST_DECODE = 3'd3,
    ST_X_ADDR = 3'd4,
    ST_X_MEM  = 3'd5,
    ST_X_ALU  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // Opcodes that need an operand address and a memory access
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/control_unit_wait_timer.sv
// Memory wait counter. Cleared on the cycle before a memory state is
// entered, counts every not-ready cycle, and flags expiry on the cycle the
// count would reach WAIT_MAX so the FSM can leave in that same cycle.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is only meaningful while actually waiting
  assign expired_o = en_i && (cnt_q == CW'(WAIT_MAX - 1));

  // Next count: clear wins, otherwise count waiting cycles, saturate at expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for a simple accumulator machine. Moore FSM
// sequencing fetch / decode / execute; strobes are decoded from the
// registered state, with ir_we, pc_inc and ac_we additionally gated by
// mem_ready so they fire only on the completing memory cycle.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OPW      = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  input  logic           mem_ready,
  output logic           ir_we,
  output logic           ar_we,
  output logic           ac_we,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [2:0]     bus_sel,
  output logic [2:0]     alu_op,
  output logic           busy,
  output logic           halted,
  output logic           err
);

  state_e     state_q, state_d;
  logic       err_q, err_d;
  logic [4:0] op;
  logic       t_clr, t_en, t_exp;

  // Opcode normalised to the 5-bit encoding space
  assign op = 5'(opcode);

  // Counter is cleared from the address states that precede each memory state
  assign t_clr = (state_q == ST_F_ADDR) || (state_q == ST_X_ADDR);
  assign t_en  = ((state_q == ST_F_MEM) || (state_q == ST_X_MEM)) && !mem_ready;

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (t_clr),
    .en_i      (t_en),
    .expired_o (t_exp)
  );

  // Next-state and sticky error logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_F_ADDR;
      ST_F_ADDR: state_d = ST_F_MEM;
      ST_F_MEM: begin
        if (mem_ready) state_d = ST_DECODE;
        else if (t_exp) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (is_mem_op(op))      state_d = ST_X_ADDR;
        else if (op == OP_INC)  state_d = ST_X_ALU;
        else if (op == OP_HALT) state_d = ST_HALT;
        else begin
          // NOP, JUMP, JMPZ refetch; anything unknown is flagged and run as NOP
          state_d = ST_F_ADDR;
          if (op != OP_NOP && op != OP_JUMP && op != OP_JMPZ) err_d = 1'b1;
        end
      end
      ST_X_ADDR: state_d = ST_X_MEM;
      ST_X_MEM: begin
        if (mem_ready) state_d = ST_F_ADDR;
        else if (t_exp) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_X_ALU:  state_d = ST_F_ADDR;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Strobe decode from registered state; reset forces IDLE so memory
  // requests drop as soon as rst_n falls
  always_comb begin
    ir_we   = 1'b0;
    ar_we   = 1'b0;
    ac_we   = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    bus_sel = BUS_NONE;
    alu_op  = ALU_PASS;
    case (state_q)
      ST_F_ADDR: begin
        bus_sel = BUS_PC;
        ar_we   = 1'b1;
      end
      ST_F_MEM: begin
        mem_rd  = 1'b1;
        bus_sel = BUS_MEM;
        ir_we   = mem_ready;
        pc_inc  = mem_ready;
      end
      ST_DECODE: begin
        if (op == OP_JUMP) begin
          bus_sel = BUS_IR;
          pc_load = 1'b1;
        end else if (op == OP_JMPZ) begin
          bus_sel = BUS_IR;
          pc_load = z_flag;
        end
      end
      ST_X_ADDR: begin
        bus_sel = BUS_IR;
        ar_we   = 1'b1;
      end
      ST_X_MEM: begin
        case (op)
          OP_LOAD: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            ac_we   = mem_ready;
          end
          OP_STORE: begin
            mem_wr  = 1'b1;
            bus_sel = BUS_AC;
          end
          OP_ADD: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            alu_op  = ALU_ADD;
            ac_we   = mem_ready;
          end
          OP_SUB: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            alu_op  = ALU_SUB;
            ac_we   = mem_ready;
          end
          default: ;
        endcase
      end
      ST_X_ALU: begin
        alu_op = ALU_INC;
        ac_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted = (state_q == ST_HALT);
  assign err    = err_q;

endmodule
